// File: rtl/cordic_fft_pkg.sv
// Shared types, constants and helpers for the CORDIC FFT accelerator.
// Angles are in binary units: 2^32 is one full turn.
package cordic_fft_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PREROT  = 3'd1,
    ST_ROTATE  = 3'd2,
    ST_GAIN    = 3'd3,
    ST_COMBINE = 3'd4,
    ST_HOLD    = 3'd5
  } state_t;

  localparam int CORDIC_K_Q16 = 39797;

  // round(atan(2^-i) / (2*pi) * 2^32)
  localparam logic [31:0] ATAN_TAB [32] = '{
    32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
    32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
    32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
    32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
    32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
    32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
    32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
    32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
  };

  function automatic logic signed [63:0] sat_to(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic signed [63:0] half_up(
    input logic signed [63:0] v
  );
    return (v + 64'sd1) >>> 1;
  endfunction

endpackage

// File: rtl/cordic_rotate_iter.sv
// Iterative CORDIC rotator: load on start, one micro-rotation per cycle.
// finished is high during the last iteration cycle.
module cordic_rotate_iter
  import cordic_fft_pkg::*;
#(
  parameter int W          = 18,
  parameter int ANGLE_W    = 32,
  parameter int ITERATIONS = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic signed [W-1:0] x0,
  input  logic signed [W-1:0] y0,
  input  logic [ANGLE_W-1:0]  z0,
  output logic signed [W-1:0] x,
  output logic signed [W-1:0] y,
  output logic                finished
);

  localparam int CW = $clog2(ITERATIONS);

  logic [ANGLE_W-1:0] z;
  logic [CW-1:0]      cnt;
  logic               busy;
  logic [4:0]         idx;
  logic [ANGLE_W-1:0] step;
  logic               pos;

  always_comb begin
    idx      = 5'(cnt);
    step     = ANGLE_W'(ATAN_TAB[idx] >> (32 - ANGLE_W));
    pos      = ~z[ANGLE_W-1];
    finished = busy && (cnt == CW'(ITERATIONS - 1));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x    <= '0;
      y    <= '0;
      z    <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      x    <= x0;
      y    <= y0;
      z    <= z0;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      x    <= pos ? x - (y >>> cnt) : x + (y >>> cnt);
      y    <= pos ? y + (x >>> cnt) : y - (x >>> cnt);
      z    <= pos ? z - step : z + step;
      cnt  <= cnt + 1'b1;
      if (finished) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/cordic_butterfly_pipe.sv
// Radix-2 DIT butterfly: out1 = a + W*b, out2 = a - W*b, W = e^(j*zangle).
// One butterfly in flight; valid/ready on both sides.
module cordic_butterfly_pipe
  import cordic_fft_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ANGLE_W    = 32,
  parameter int ITERATIONS = 16,
  parameter int SCALE      = 0
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] x1,
  input  logic signed [DATA_W-1:0] y1,
  input  logic signed [DATA_W-1:0] x2,
  input  logic signed [DATA_W-1:0] y2,
  input  logic [ANGLE_W-1:0]       zangle,
  input  logic                     inverse,
  output logic signed [DATA_W-1:0] xout1,
  output logic signed [DATA_W-1:0] yout1,
  output logic signed [DATA_W-1:0] xout2,
  output logic signed [DATA_W-1:0] yout2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     done
);

  localparam int IW = DATA_W + 2;
  localparam int PW = IW + 18;
  localparam logic signed [PW-1:0] KQ   = PW'(CORDIC_K_Q16);
  localparam logic signed [PW-1:0] HALF = PW'(32768);

  state_t state;

  logic signed [DATA_W-1:0] ax, ay, bx, by;
  logic [ANGLE_W-1:0]       ang;
  logic                     inv;

  logic [ANGLE_W-1:0]       theta;
  logic                     wrap;
  logic signed [IW-1:0]     bxe, bye;
  logic                     rot_start;
  logic signed [IW-1:0]     rot_x0, rot_y0;
  logic [ANGLE_W-1:0]       rot_z0;
  logic signed [IW-1:0]     rot_x, rot_y;
  logic                     rot_fin;

  logic signed [PW-1:0]     px, py;
  logic signed [IW-1:0]     gx, gy;
  logic signed [IW-1:0]     s1x, s1y, s2x, s2y;

  function automatic logic signed [DATA_W-1:0] finalize(
    input logic signed [IW-1:0] s
  );
    logic signed [63:0] v;
    v = 64'(s);
    if (SCALE != 0) v = half_up(v);
    return DATA_W'(sat_to(v, DATA_W));
  endfunction

  assign in_ready = (state == ST_IDLE);

  // Fold |theta| > 90 deg into range by negating b and adding 180 deg.
  always_comb begin
    theta     = inv ? -ang : ang;
    wrap      = theta[ANGLE_W-1] ^ theta[ANGLE_W-2];
    bxe       = IW'(bx);
    bye       = IW'(by);
    rot_start = (state == ST_PREROT);
    rot_x0    = wrap ? -bxe : bxe;
    rot_y0    = wrap ? -bye : bye;
    rot_z0    = wrap ? theta + {1'b1, {(ANGLE_W-1){1'b0}}} : theta;
  end

  always_comb begin
    px  = PW'(rot_x) * KQ;
    py  = PW'(rot_y) * KQ;
    s1x = IW'(ax) + gx;
    s1y = IW'(ay) + gy;
    s2x = IW'(ax) - gx;
    s2y = IW'(ay) - gy;
  end

  cordic_rotate_iter #(
    .W         (IW),
    .ANGLE_W   (ANGLE_W),
    .ITERATIONS(ITERATIONS)
  ) u_rot (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (rot_start),
    .x0      (rot_x0),
    .y0      (rot_y0),
    .z0      (rot_z0),
    .x       (rot_x),
    .y       (rot_y),
    .finished(rot_fin)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      ax        <= '0;
      ay        <= '0;
      bx        <= '0;
      by        <= '0;
      ang       <= '0;
      inv       <= 1'b0;
      gx        <= '0;
      gy        <= '0;
      xout1     <= '0;
      yout1     <= '0;
      xout2     <= '0;
      yout2     <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: if (in_valid) begin
          ax    <= x1;
          ay    <= y1;
          bx    <= x2;
          by    <= y2;
          ang   <= zangle;
          inv   <= inverse;
          state <= ST_PREROT;
        end
        ST_PREROT: state <= ST_ROTATE;
        ST_ROTATE: if (rot_fin) state <= ST_GAIN;
        ST_GAIN: begin
          gx    <= IW'((px + HALF) >>> 16);
          gy    <= IW'((py + HALF) >>> 16);
          state <= ST_COMBINE;
        end
        ST_COMBINE: begin
          xout1     <= finalize(s1x);
          yout1     <= finalize(s1y);
          xout2     <= finalize(s2x);
          yout2     <= finalize(s2y);
          out_valid <= 1'b1;
          done      <= 1'b1;
          state     <= ST_HOLD;
        end
        ST_HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_butterfly_pipe.sv
// Bench for cordic_butterfly_pipe: directed and random butterflies
// against a floating-point reference, unscaled and scaled instances.
module tb_cordic_butterfly_pipe;

  localparam int DW = 16;
  localparam int AW = 32;
  localparam int IT = 16;
  localparam real PI = 3.14159265358979323846;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic inverse = 1'b0;
  logic signed [DW-1:0] x1 = '0, y1 = '0, x2 = '0, y2 = '0;
  logic [AW-1:0] zangle = '0;

  logic [1:0] rdy, vld, dn;
  logic signed [DW-1:0] xo1 [2];
  logic signed [DW-1:0] yo1 [2];
  logic signed [DW-1:0] xo2 [2];
  logic signed [DW-1:0] yo2 [2];

  int n_cmp = 0;
  int n_bad = 0;
  int e0 [4];
  int e1 [4];

  always #5 clock = ~clock;

  cordic_butterfly_pipe #(
    .DATA_W(DW), .ANGLE_W(AW), .ITERATIONS(IT), .SCALE(0)
  ) u_dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(rdy[0]),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .zangle(zangle), .inverse(inverse),
    .xout1(xo1[0]), .yout1(yo1[0]),
    .xout2(xo2[0]), .yout2(yo2[0]),
    .out_valid(vld[0]), .out_ready(out_ready), .done(dn[0])
  );

  cordic_butterfly_pipe #(
    .DATA_W(DW), .ANGLE_W(AW), .ITERATIONS(IT), .SCALE(1)
  ) u_dut_s (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(rdy[1]),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .zangle(zangle), .inverse(inverse),
    .xout1(xo1[1]), .yout1(yo1[1]),
    .xout2(xo2[1]), .yout2(yo2[1]),
    .out_valid(vld[1]), .out_ready(out_ready), .done(dn[1])
  );

  task automatic chk(input string tag, input int obs, input int exp,
                     input int tol = 0);
    n_cmp++;
    if (obs - exp > tol || exp - obs > tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic int clamp_round(input real r);
    if (r > 32767.0) return 32767;
    if (r < -32768.0) return -32768;
    return int'(r);
  endfunction

  // Ideal butterfly in floating point, then scaling and saturation.
  task automatic model(input int ax, ay, bx, by,
                       input logic [AW-1:0] z, input logic inv);
    logic [AW-1:0] t;
    int ts;
    real th, wr, wi;
    real v [4];
    t  = inv ? -z : z;
    ts = $signed(t);
    th = real'(ts) * 2.0 * PI / 4294967296.0;
    wr = real'(bx) * $cos(th) - real'(by) * $sin(th);
    wi = real'(bx) * $sin(th) + real'(by) * $cos(th);
    v[0] = real'(ax) + wr;
    v[1] = real'(ay) + wi;
    v[2] = real'(ax) - wr;
    v[3] = real'(ay) - wi;
    for (int k = 0; k < 4; k++) begin
      e0[k] = clamp_round(v[k]);
      e1[k] = clamp_round(v[k] / 2.0);
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_x1"},  xo1[0], e0[0], 3);
    chk({tag, "_y1"},  yo1[0], e0[1], 3);
    chk({tag, "_x2"},  xo2[0], e0[2], 3);
    chk({tag, "_y2"},  yo2[0], e0[3], 3);
    chk({tag, "_x1s"}, xo1[1], e1[0], 3);
    chk({tag, "_y1s"}, yo1[1], e1[1], 3);
    chk({tag, "_x2s"}, xo2[1], e1[2], 3);
    chk({tag, "_y2s"}, yo2[1], e1[3], 3);
  endtask

  task automatic run_bf(input int ax, ay, bx, by,
                        input logic [AW-1:0] z, input logic inv,
                        input int hold, input bit poke);
    int cyc;
    bit got;
    model(ax, ay, bx, by, z, inv);
    @(negedge clock);
    chk("rdy_idle", int'(rdy), 3);
    x1 = DW'(ax); y1 = DW'(ay); x2 = DW'(bx); y2 = DW'(by);
    zangle = z; inverse = inv; in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    x1 = DW'($urandom); y1 = DW'($urandom);
    x2 = DW'($urandom); y2 = DW'($urandom);
    zangle = $urandom; inverse = 1'($urandom);
    cyc = 0;
    got = 1'b0;
    while (cyc < 100 && !got) begin
      @(posedge clock);
      #1;
      cyc++;
      if (poke && cyc == 4) begin
        chk("rdy_busy", int'(rdy), 0);
        in_valid = 1'b1;
      end
      if (cyc == 5) in_valid = 1'b0;
      got = vld[0];
    end
    chk("latency", cyc, IT + 3);
    chk("vld_both", int'(vld), 3);
    chk("done_rise", int'(dn), 3);
    check_outs("res");
    for (int k = 0; k < hold; k++) begin
      @(posedge clock);
      #1;
      chk("hold_vld", int'(vld), 3);
      chk("hold_rdy", int'(rdy), 0);
      chk("hold_done", int'(dn), 0);
      check_outs("hold");
    end
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    chk("post_vld", int'(vld), 0);
    chk("post_rdy", int'(rdy), 3);
    check_outs("keep");
  endtask

  function automatic int rnd_op();
    return int'($urandom_range(24000)) - 12000;
  endfunction

  initial begin
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_rdy", int'(rdy), 3);
    chk("rst_vld", int'(vld), 0);
    chk("rst_done", int'(dn), 0);
    chk("rst_x1", xo1[0], 0);
    chk("rst_y2", yo2[1], 0);
    reset_n = 1'b1;

    run_bf(3200, 0, 3200, 0, 32'hE0000000, 1'b0, 2, 1'b1);
    chk("t1_x1", xo1[0], 5463, 3);
    chk("t1_y1", yo1[0], -2263, 3);
    run_bf(1000, 500, 200, -100, 32'h0, 1'b0, 1, 1'b0);
    chk("t2_x2", xo2[0], 800, 3);
    run_bf(3200, 0, 3200, 0, 32'hE0000000, 1'b1, 1, 1'b0);
    chk("t3_y1", yo1[0], 2263, 3);
    run_bf(3200, 0, 3200, 0, 32'h80000000, 1'b0, 1, 1'b0);
    chk("t3_x2", xo2[0], 6400, 3);
    run_bf(3200, 0, 3200, 0, 32'h80000000, 1'b1, 1, 1'b0);
    run_bf(-500, 700, 4000, 2500, 32'h40000000, 1'b0, 1, 1'b0);
    run_bf(30000, 0, 30000, 0, 32'h0, 1'b0, 1, 1'b0);
    chk("sat_hi", xo1[0], 32767);
    chk("sat_hi_s", xo1[1], 30000, 3);
    run_bf(-30000, 0, -30000, 0, 32'h0, 1'b0, 1, 1'b0);
    chk("sat_lo", xo1[0], -32768);
    run_bf(1234, -4321, 2222, 3333, 32'h1234_5678, 1'b0, 5, 1'b0);
    run_bf(-1000, 2000, -3000, 4000, 32'hC000_1000, 1'b1, 1, 1'b0);

    // abort in the middle of the rotation
    @(negedge clock);
    x1 = 16'sd1000; y1 = 16'sd500; x2 = 16'sd200; y2 = -16'sd100;
    zangle = '0; inverse = 1'b0; in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    repeat (8) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_rdy", int'(rdy), 3);
    chk("arst_vld", int'(vld), 0);
    chk("arst_x1", xo1[0], 0);
    chk("arst_y1", yo1[0], 0);
    chk("arst_x2", xo2[1], 0);
    chk("arst_y2", yo2[1], 0);
    @(negedge clock);
    reset_n = 1'b1;
    run_bf(1000, 500, 200, -100, 32'h0, 1'b0, 1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      run_bf(rnd_op(), rnd_op(), rnd_op(), rnd_op(), $urandom,
             1'($urandom), int'($urandom_range(3)) + 1, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
